// File: rtl/playback_ctrl_if.sv
// playback_ctrl_if
//   Bundles the player-FSM controls, the interpolator/DAC handshakes and the
//   SRAM address for the playback sequencer.
//   master : player side (drives the i_* controls, observes the o_* results)
//   slave  : playback_ctrl itself
//   i_start/i_pause/i_stop  one-cycle control pulses
//   i_mode/i_speed          1=fast/0=slow, speed factor (clamped 1..8)
//   i_end_addr              last valid sample address (inclusive)
//   i_dac_req               one pulse per DAC output sample slot
//   o_sram_addr             sample address to SRAM
//   o_intp_valid            interpolator latches SRAM data
//   o_phase                 slow-mode sub-sample phase
//   o_out_valid             interpolator output is current
//   o_playing/o_done/o_underrun  status
interface playback_ctrl_if;
   logic        i_start;
   logic        i_pause;
   logic        i_stop;
   logic        i_mode;
   logic [3:0]  i_speed;
   logic [19:0] i_end_addr;
   logic        i_dac_req;
   logic [19:0] o_sram_addr;
   logic        o_intp_valid;
   logic [2:0]  o_phase;
   logic        o_out_valid;
   logic        o_playing;
   logic        o_done;
   logic        o_underrun;

   modport master (
      output i_start, i_pause, i_stop, i_mode, i_speed, i_end_addr, i_dac_req,
      input  o_sram_addr, o_intp_valid, o_phase, o_out_valid, o_playing,
             o_done, o_underrun
   );

   modport slave (
      input  i_start, i_pause, i_stop, i_mode, i_speed, i_end_addr, i_dac_req,
      output o_sram_addr, o_intp_valid, o_phase, o_out_valid, o_playing,
             o_done, o_underrun
   );
endinterface

// File: rtl/playback_ctrl.sv
// playback_ctrl
//   Playback sequencer: walks SRAM sample addresses at fast (skip S) or slow
//   (S interpolated phases per sample) speed, one step per DAC sample slot.
//   Ports:
//     i_clk    system clock
//     i_rst_n  asynchronous reset, active low
//     bus      playback_ctrl_if.slave (controls, SRAM address, strobes)
//   All outputs are registered.
module playback_ctrl (
   input  logic             i_clk,
   input  logic             i_rst_n,
   playback_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAIT,
      S_PAUSE
   } state_t;

   state_t      state;
   logic [19:0] addr;
   logic [2:0]  phase;
   logic [3:0]  spd;
   logic        fast;
   logic        prime;
   logic        intp_q;
   logic        out_q;
   logic        play_q;
   logic        done_q;
   logic        under_q;

   logic [3:0]  speed_clamp;
   logic [20:0] end_ext;
   logic [20:0] fast_next;
   logic [20:0] slow_next;
   logic        last_phase;

   always_comb begin
      speed_clamp = bus.i_speed;
      if (bus.i_speed == '0)
         speed_clamp = 4'd1;
      else if (bus.i_speed > 4'd8)
         speed_clamp = 4'd8;
   end

   // 21-bit sums so a step past 0xFFFFF is seen as beyond the end address
   assign end_ext    = {1'b0, bus.i_end_addr};
   assign fast_next  = {1'b0, addr} + {17'd0, spd};
   assign slow_next  = {1'b0, addr} + 21'd1;
   assign last_phase = ({1'b0, phase} == (spd - 4'd1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         addr    <= '0;
         phase   <= '0;
         spd     <= 4'd1;
         fast    <= 1'b0;
         prime   <= 1'b0;
         intp_q  <= 1'b0;
         out_q   <= 1'b0;
         play_q  <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         intp_q  <= 1'b0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
         if (bus.i_stop && (state != S_IDLE)) begin
            state  <= S_IDLE;
            addr   <= '0;
            phase  <= '0;
            prime  <= 1'b0;
            play_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.i_start) begin
                     addr   <= '0;
                     phase  <= '0;
                     spd    <= speed_clamp;
                     fast   <= bus.i_mode;
                     prime  <= 1'b1;
                     state  <= S_FETCH;
                     play_q <= 1'b1;
                  end
               end
               S_FETCH: begin
                  under_q <= bus.i_dac_req;
                  intp_q  <= 1'b1;
                  state   <= S_LOAD;
               end
               S_LOAD: begin
                  under_q <= bus.i_dac_req;
                  prime   <= 1'b0;
                  // slow start loads both interpolator taps before waiting
                  if (prime && !fast && (addr < bus.i_end_addr)) begin
                     addr  <= addr + 20'd1;
                     state <= S_FETCH;
                  end else begin
                     state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (bus.i_pause) begin
                     state  <= S_PAUSE;
                     play_q <= 1'b0;
                  end else if (bus.i_dac_req) begin
                     out_q <= 1'b1;
                     if (fast) begin
                        if (fast_next > end_ext) begin
                           done_q <= 1'b1;
                           state  <= S_IDLE;
                           play_q <= 1'b0;
                        end else begin
                           addr  <= fast_next[19:0];
                           state <= S_FETCH;
                        end
                     end else if (!last_phase) begin
                        phase <= phase + 3'd1;
                     end else begin
                        phase <= '0;
                        if (slow_next > end_ext) begin
                           done_q <= 1'b1;
                           state  <= S_IDLE;
                           play_q <= 1'b0;
                        end else begin
                           addr  <= slow_next[19:0];
                           state <= S_FETCH;
                        end
                     end
                  end
               end
               S_PAUSE: begin
                  // resume keeps the address and the loaded taps: no refetch
                  if (bus.i_start) begin
                     spd    <= speed_clamp;
                     fast   <= bus.i_mode;
                     phase  <= '0;
                     state  <= S_WAIT;
                     play_q <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_sram_addr  = addr;
   assign bus.o_phase      = phase;
   assign bus.o_intp_valid = intp_q;
   assign bus.o_out_valid  = out_q;
   assign bus.o_playing    = play_q;
   assign bus.o_done       = done_q;
   assign bus.o_underrun   = under_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// tb_playback_ctrl
//   Directed bench for playback_ctrl. A position-based reference model
//   (position counted in sub-sample units) predicts every output each cycle;
//   directed scenarios pin the model with hand-computed literal values.
module tb_playback_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   playback_ctrl_if bus();

   playback_ctrl dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   localparam int M_IDLE  = 0;
   localparam int M_PIPE  = 1;
   localparam int M_WAIT  = 2;
   localparam int M_PAUSE = 3;

   int m_st    = M_IDLE;
   int m_stage = 0;      // 0: address presented, 1: data loading
   int m_pos   = 0;      // playback position in sub-sample units
   int m_unit  = 1;      // sub-samples per SRAM sample (S slow, 1 fast)
   int m_step  = 1;      // sub-samples advanced per request (S fast, 1 slow)
   bit m_fast  = 1'b0;
   bit m_prime = 1'b0;

   logic [19:0] e_addr  = '0;
   logic [2:0]  e_phase = '0;
   logic e_intp = 1'b0, e_out = 1'b0, e_play = 1'b0, e_done = 1'b0, e_under = 1'b0;

   function automatic int clamp_speed(int sp);
      if (sp == 0) return 1;
      if (sp > 8) return 8;
      return sp;
   endfunction

   task automatic model_latch();
      int s;
      s      = clamp_speed(int'(bus.i_speed));
      m_fast = bus.i_mode;
      m_unit = m_fast ? 1 : s;
      m_step = m_fast ? s : 1;
   endtask

   task automatic model_step();
      int a, nxt, e;
      e_intp = 1'b0; e_out = 1'b0; e_done = 1'b0; e_under = 1'b0;
      a = m_pos / m_unit;
      e = int'(bus.i_end_addr);
      if (bus.i_stop && m_st != M_IDLE) begin
         m_st = M_IDLE; m_pos = 0; m_prime = 1'b0;
      end else begin
         case (m_st)
            M_IDLE: if (bus.i_start) begin
               model_latch();
               m_pos = 0; m_prime = 1'b1; m_st = M_PIPE; m_stage = 0;
            end
            M_PIPE: begin
               if (bus.i_dac_req) e_under = 1'b1;
               if (m_stage == 0) begin
                  m_stage = 1; e_intp = 1'b1;
               end else if (m_prime && !m_fast && a < e) begin
                  m_pos = m_pos + m_unit; m_prime = 1'b0; m_stage = 0;
               end else begin
                  m_prime = 1'b0; m_st = M_WAIT;
               end
            end
            M_WAIT: begin
               if (bus.i_pause) m_st = M_PAUSE;
               else if (bus.i_dac_req) begin
                  e_out = 1'b1;
                  nxt = m_pos + m_step;
                  if (nxt % m_unit != 0) m_pos = nxt;
                  else if (nxt / m_unit > e) begin
                     e_done = 1'b1; m_st = M_IDLE; m_pos = a * m_unit;
                  end else begin
                     m_pos = nxt; m_st = M_PIPE; m_stage = 0;
                  end
               end
            end
            default: if (bus.i_start) begin
               model_latch();
               m_pos = a * m_unit; m_st = M_WAIT;
            end
         endcase
      end
      e_addr  = 20'(m_pos / m_unit);
      e_phase = 3'(m_pos % m_unit);
      e_play  = (m_st == M_PIPE) || (m_st == M_WAIT);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = M_IDLE; m_stage = 0; m_pos = 0; m_unit = 1; m_step = 1;
         m_fast = 1'b0; m_prime = 1'b0;
         e_addr = '0; e_phase = '0;
         e_intp = 1'b0; e_out = 1'b0; e_play = 1'b0; e_done = 1'b0; e_under = 1'b0;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [28:0] got_v, exp_v;
   always @(negedge clk) begin
      got_v = {bus.o_sram_addr, bus.o_phase, bus.o_intp_valid, bus.o_out_valid,
               bus.o_playing, bus.o_done, bus.o_underrun};
      exp_v = {e_addr, e_phase, e_intp, e_out, e_play, e_done, e_under};
      n_checks++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t: got addr=%0d ph=%0d iv=%b ov=%b pl=%b dn=%b ur=%b, expected addr=%0d ph=%0d iv=%b ov=%b pl=%b dn=%b ur=%b",
                  $time, got_v[28:9], got_v[8:6], got_v[5], got_v[4], got_v[3], got_v[2], got_v[1],
                  exp_v[28:9], exp_v[8:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1]);
      end
   end

   // ---------------- event log for literal checks ----------------
   int q_addr[$];
   int q_ph[$];
   int n_out = 0, n_done = 0, n_under = 0;

   always @(negedge clk) begin
      if (bus.o_intp_valid === 1'b1) q_addr.push_back(int'(bus.o_sram_addr));
      if (bus.o_out_valid  === 1'b1) n_out++;
      if (bus.o_done       === 1'b1) n_done++;
      if (bus.o_underrun   === 1'b1) n_under++;
   end

   function automatic int qa(int i);
      return (i < q_addr.size()) ? q_addr[i] : -1;
   endfunction

   function automatic int qp(int i);
      return (i < q_ph.size()) ? q_ph[i] : -1;
   endfunction

   task automatic chk(string name, int got, int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic clr();
      q_addr.delete(); q_ph.delete();
      n_out = 0; n_done = 0; n_under = 0;
   endtask

   task automatic tick(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(bit mode, int sp, int end_a);
      bus.i_mode = mode; bus.i_speed = 4'(sp); bus.i_end_addr = 20'(end_a);
      bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
   endtask

   task automatic req();
      q_ph.push_back(int'(bus.o_phase));
      bus.i_dac_req = 1'b1; tick(); bus.i_dac_req = 1'b0;
      tick(3);
   endtask

   task automatic pulse_stop();
      bus.i_stop = 1'b1; tick(); bus.i_stop = 1'b0; tick();
   endtask

   task automatic pulse_pause();
      bus.i_pause = 1'b1; tick(); bus.i_pause = 1'b0; tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 1'b0;
      bus.i_speed = '0; bus.i_end_addr = '0; bus.i_dac_req = 1'b0;
      tick(2);
      chk("rst_addr", int'(bus.o_sram_addr), 0);
      chk("rst_playing", int'(bus.o_playing), 0);
      rst_n = 1'b1;
      tick(2);

      // fast, S=3, end=10
      clr();
      pulse_start(1'b1, 3, 10); tick(3);
      repeat (4) req();
      chk("fast_nfetch", q_addr.size(), 4);
      chk("fast_a0", qa(0), 0);
      chk("fast_a1", qa(1), 3);
      chk("fast_a2", qa(2), 6);
      chk("fast_a3", qa(3), 9);
      chk("fast_nout", n_out, 4);
      chk("fast_done", n_done, 1);
      chk("fast_playing", int'(bus.o_playing), 0);

      // slow, S=4, end=2
      clr();
      pulse_start(1'b0, 4, 2); tick(5);
      chk("slow_prime_n", q_addr.size(), 2);
      chk("slow_prime_a1", qa(1), 1);
      repeat (7) req();
      chk("slow_nodone7", n_done, 0);
      req();
      chk("slow_ph0", qp(0), 0);
      chk("slow_ph1", qp(1), 1);
      chk("slow_ph2", qp(2), 2);
      chk("slow_ph3", qp(3), 3);
      chk("slow_ph4", qp(4), 0);
      chk("slow_a2", qa(2), 2);
      chk("slow_nfetch", q_addr.size(), 3);
      chk("slow_nout", n_out, 8);
      chk("slow_done", n_done, 1);

      // speed clamp
      clr();
      pulse_start(1'b1, 0, 5); tick(3);
      req(); req();
      chk("clamp0_a1", qa(1), 1);
      chk("clamp0_a2", qa(2), 2);
      pulse_stop();
      chk("stop_addr", int'(bus.o_sram_addr), 0);
      chk("stop_nodone", n_done, 0);
      clr();
      pulse_start(1'b1, 12, 100); tick(3);
      req(); req();
      chk("clamp12_a1", qa(1), 8);
      chk("clamp12_a2", qa(2), 16);
      pulse_stop();

      // pause / resume
      clr();
      pulse_start(1'b0, 2, 50); tick(5);
      req(); req();
      chk("pause_addr_pre", int'(bus.o_sram_addr), 2);
      pulse_pause();
      chk("pause_playing", int'(bus.o_playing), 0);
      repeat (3) req();
      chk("pause_nout", n_out, 2);
      pulse_start(1'b0, 3, 50); tick();
      chk("resume_phase", int'(bus.o_phase), 0);
      chk("resume_addr", int'(bus.o_sram_addr), 2);
      chk("resume_playing", int'(bus.o_playing), 1);
      chk("resume_nofetch", q_addr.size(), 3);
      req();
      chk("resume_ph1", int'(bus.o_phase), 1);
      chk("resume_nout", n_out, 3);
      pulse_stop();

      // underrun, then stop+pause collision
      clr();
      pulse_start(1'b1, 1, 50); tick(3);
      bus.i_dac_req = 1'b1; tick(2); bus.i_dac_req = 1'b0; tick(3);
      chk("under_n", n_under, 1);
      chk("under_nout", n_out, 1);
      chk("under_addr", int'(bus.o_sram_addr), 1);
      bus.i_stop = 1'b1; bus.i_pause = 1'b1; tick();
      bus.i_stop = 1'b0; bus.i_pause = 1'b0; tick();
      chk("stoppause_addr", int'(bus.o_sram_addr), 0);
      chk("stoppause_playing", int'(bus.o_playing), 0);
      chk("stoppause_nodone", n_done, 0);

      // async reset mid-WAIT at addr 37
      clr();
      pulse_start(1'b1, 8, 100); tick(3);
      repeat (4) req();
      pulse_pause();
      pulse_start(1'b1, 5, 100); tick();
      req();
      chk("rst37_addr_pre", int'(bus.o_sram_addr), 37);
      chk("rst37_playing_pre", int'(bus.o_playing), 1);
      rst_n = 1'b0;
      #2;
      chk("rst37_addr", int'(bus.o_sram_addr), 0);
      chk("rst37_playing", int'(bus.o_playing), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst37_addr_post", int'(bus.o_sram_addr), 0);
      chk("rst37_phase_post", int'(bus.o_phase), 0);
      chk("rst37_playing_post", int'(bus.o_playing), 0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/playback_ctrl.md
# playback_ctrl

Playback sequencer for the audio player path. It walks SRAM sample addresses at normal, fast (skip) or slow (interpolated) speed, one step per DAC sample slot. It strobes each fetched sample into the interpolator and tells the interpolator which sub-sample phase to emit. It sits between the top-level player FSM (start/pause/stop) and the interpolator / DAC sender.

## Interface
- No parameters; address width fixed at 20 (1M x 16 SRAM).
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous reset, active low
- i_start  in  1  one-cycle pulse: start from address 0 (IDLE), or resume (PAUSE)
- i_pause  in  1  one-cycle pulse: pause playback
- i_stop  in  1  one-cycle pulse: abort playback, return to IDLE
- i_mode  in  1  1 = fast, 0 = slow; latched on start/resume
- i_speed  in  4  speed factor; 0 → 1, 9..15 → 8; clamped value latched on start/resume
- i_end_addr  in  20  last valid sample address (inclusive)
- i_dac_req  in  1  one-cycle pulse per output sample slot
- o_sram_addr  out  20  sample address to SRAM
- o_intp_valid  out  1  one-cycle strobe: interpolator latches SRAM data now
- o_phase  out  3  slow-mode phase 0..S-1 (S = latched speed); 0 in fast mode
- o_out_valid  out  1  one-cycle strobe: interpolator output is current, DAC sender takes it
- o_playing  out  1  high in every state except IDLE and PAUSE
- o_done  out  1  one-cycle pulse when playback reaches end of data
- o_underrun  out  1  one-cycle pulse when i_dac_req arrives during FETCH/LOAD

## Operation
- States: IDLE, FETCH, LOAD, WAIT, PAUSE.
- IDLE + i_start:
  - addr=0, phase=0, latch mode/speed, prime=1 → FETCH.
- FETCH (1 cycle): o_sram_addr holds addr (SRAM read latency 1 cycle) → LOAD.
- LOAD (1 cycle): o_intp_valid=1.
  - If prime=1 and slow mode and addr<end: addr+=1, prime=0 → FETCH. This fills both interpolator taps.
  - Otherwise prime=0 → WAIT.
- WAIT + i_dac_req: o_out_valid pulses next cycle, then advance.
  - Fast: next=addr+S (21-bit sum). If next>end: o_done, → IDLE. Else addr=next → FETCH.
  - Slow, phase<S-1: phase+=1, stay WAIT, no fetch.
  - Slow, phase==S-1: phase=0. If addr+1>end: o_done, → IDLE. Else addr+=1 → FETCH.
  - S==1 in slow mode behaves as normal speed: every request fetches.
- WAIT + i_pause → PAUSE. i_dac_req ignored in PAUSE.
- PAUSE + i_start: re-latch mode/speed, phase=0 → WAIT. addr unchanged, no refetch.
- i_stop in any non-IDLE state → IDLE, addr=0, phase=0, no o_done.
- Priority in the same cycle: i_stop > i_pause > i_start > i_dac_req. A pause/dac_req collision pauses; that request produces no o_out_valid.
- i_dac_req in FETCH/LOAD: o_underrun pulses, request dropped, sequencing continues.
- i_pause in FETCH/LOAD: ignored.
- i_start outside IDLE/PAUSE: ignored.
- i_end_addr=0 in slow mode: one fetch, no prime. The first dac_req completing phase S-1 ends playback.

## Timing
- Reset: state IDLE; o_sram_addr=0, o_phase=0; all strobes and o_playing = 0.
- Start → first o_intp_valid: 2 cycles.
- Slow-mode prime: second o_intp_valid 2 cycles after the first.
- i_dac_req → o_out_valid: exactly 1 cycle (registered).
- Fetch triggered by a request: FETCH is the cycle after i_dac_req, LOAD the next. o_out_valid is coincident with FETCH, so DAC data reflects the pre-advance sample/phase.
- o_done: asserted the cycle after the terminating i_dac_req, together with o_out_valid; state IDLE from that cycle.
- All outputs registered; async reset mid-play returns to reset values immediately.

## Test plan
- Reset mid-WAIT with addr=37 → all outputs 0, state IDLE on the next clock after release.
- Fast, speed=3, end=10; start, 4 dac_reqs.
  - o_sram_addr sequence 0,3,6,9.
  - 4th request: next=12>10, o_done and IDLE.
- Slow, speed=4, end=2; start.
  - Prime fetches addr 0,1.
  - o_phase 0,1,2,3,0 across requests; addr 1→2 on the 4th.
  - o_done on the 8th request.
- Speed clamp: i_speed=0 fast → addr steps of 1; i_speed=12 → steps of 8.
- Pause after 2 reqs (slow, S=2), 3 dac_reqs while paused → no o_out_valid. Start with speed 3 → phase restarts at 0, addr unchanged.
- dac_req one cycle after a fetch-triggering request → o_underrun pulse, no extra o_out_valid. Stop+pause same cycle → IDLE, addr 0, no o_done.
